alu_seq: RTL and testbench

- Parametrised successor to the 8-bit datapath ALU, for the wider CPU datapath.
- Single-cycle ops:
  - pass-through, add/sub with carry/borrow, logic;
  - barrel shifts/rotates with arbitrary count.
- Multi-cycle ops: unsigned iterative multiply (MULU) and divide (DIVU), via a start/busy/done handshake.
- Result and flags (Z, S, C, OF) are registered; the carry flag feeds ADC/SBB chaining. Sits between register file and writeback; the control unit issues one op at a time.

---
 rtl/alu_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops with registered result and flags,
// plus iterative unsigned multiply (shift-add) and divide (restoring) behind start/busy/done.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_Start,
    input  logic [4:0]       i_ALUOp,
    input  logic [WIDTH-1:0] i_Data1,
    input  logic [WIDTH-1:0] i_Data2,
    output logic [WIDTH-1:0] o_Result,
    output logic [WIDTH-1:0] o_ResultHi,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Z,
    output logic             o_S,
    output logic             o_C,
    output logic             o_OF
);

    localparam logic [4:0] OpPd1  = 5'd0;
    localparam logic [4:0] OpPd2  = 5'd1;
    localparam logic [4:0] OpAdd  = 5'd2;
    localparam logic [4:0] OpSub  = 5'd3;
    localparam logic [4:0] OpAdc  = 5'd4;
    localparam logic [4:0] OpSbb  = 5'd5;
    localparam logic [4:0] OpAnd  = 5'd6;
    localparam logic [4:0] OpOr   = 5'd7;
    localparam logic [4:0] OpXor  = 5'd8;
    localparam logic [4:0] OpNot  = 5'd9;
    localparam logic [4:0] OpShl  = 5'd10;
    localparam logic [4:0] OpShr  = 5'd11;
    localparam logic [4:0] OpSar  = 5'd12;
    localparam logic [4:0] OpRol  = 5'd13;
    localparam logic [4:0] OpRor  = 5'd14;
    localparam logic [4:0] OpMulu = 5'd15;
    localparam logic [4:0] OpDivu = 5'd16;

    localparam logic [SHW:0] CntInit = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CntOne  = (SHW+1)'(1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [SHW:0]     cnt_q;

    // Shifter: counts >= WIDTH are flagged separately, so only the low SHW bits steer the shift.
    logic [SHW-1:0]   sh_amt;
    logic             sh_big;
    logic [WIDTH:0]   shl_ext, shr_ext, sar_ext;
    logic [WIDTH-1:0] rol_res, ror_res;

    assign sh_amt  = i_Data2[SHW-1:0];
    assign sh_big  = |(i_Data2 >> SHW);
    assign shl_ext = {1'b0, i_Data1} << sh_amt;
    assign shr_ext = {i_Data1, 1'b0} >> sh_amt;
    assign sar_ext = $signed({i_Data1, 1'b0}) >>> sh_amt;
    assign rol_res = WIDTH'(({i_Data1, i_Data1} << sh_amt) >> WIDTH);
    assign ror_res = WIDTH'({i_Data1, i_Data1} >> sh_amt);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_z, sc_s, sc_c, sc_of, sc_zs;

    always_comb begin
        sum    = '0;
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = o_C;
        sc_of  = o_OF;
        sc_zs  = 1'b1;
        case (i_ALUOp)
            OpPd1: begin sc_res = i_Data1; sc_zs = 1'b0; end
            OpPd2: begin sc_res = i_Data2; sc_zs = 1'b0; end
            OpNot: begin sc_res = ~i_Data1; sc_zs = 1'b0; end
            OpAdd, OpAdc: begin
                sum    = {1'b0, i_Data1} + {1'b0, i_Data2}
                       + {{WIDTH{1'b0}}, (i_ALUOp == OpAdc) & o_C};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_of  = (i_Data1[WIDTH-1] == i_Data2[WIDTH-1])
                         && (sum[WIDTH-1] != i_Data1[WIDTH-1]);
            end
            OpSub, OpSbb: begin
                sum    = {1'b0, i_Data1} - {1'b0, i_Data2}
                       - {{WIDTH{1'b0}}, (i_ALUOp == OpSbb) & o_C};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_of  = (i_Data1[WIDTH-1] != i_Data2[WIDTH-1])
                         && (sum[WIDTH-1] != i_Data1[WIDTH-1]);
            end
            OpAnd: begin sc_res = i_Data1 & i_Data2; sc_c = 1'b0; sc_of = 1'b0; end
            OpOr:  begin sc_res = i_Data1 | i_Data2; sc_c = 1'b0; sc_of = 1'b0; end
            OpXor: begin sc_res = i_Data1 ^ i_Data2; sc_c = 1'b0; sc_of = 1'b0; end
            OpShl: begin
                if (sh_big) begin
                    sc_res = '0;
                    sc_c   = 1'b0;
                end else if (sh_amt != '0) begin
                    sc_res = shl_ext[WIDTH-1:0];
                    sc_c   = shl_ext[WIDTH];
                end else begin
                    sc_res = i_Data1;
                end
                sc_of = sc_res[WIDTH-1] ^ i_Data1[WIDTH-1];
            end
            OpShr: begin
                if (sh_big) begin
                    sc_res = '0;
                    sc_c   = 1'b0;
                end else if (sh_amt != '0) begin
                    sc_res = shr_ext[WIDTH:1];
                    sc_c   = shr_ext[0];
                end else begin
                    sc_res = i_Data1;
                end
                sc_of = sc_res[WIDTH-1] ^ i_Data1[WIDTH-1];
            end
            OpSar: begin
                if (sh_big) begin
                    sc_res = {WIDTH{i_Data1[WIDTH-1]}};
                    sc_c   = i_Data1[WIDTH-1];
                end else if (sh_amt != '0) begin
                    sc_res = sar_ext[WIDTH:1];
                    sc_c   = sar_ext[0];
                end else begin
                    sc_res = i_Data1;
                end
                sc_of = sc_res[WIDTH-1] ^ i_Data1[WIDTH-1];
            end
            // WIDTH is a power of two, so the low SHW count bits are already n mod WIDTH.
            OpRol: begin
                if (sh_amt != '0) begin
                    sc_res = rol_res;
                    sc_c   = rol_res[0];
                end else begin
                    sc_res = i_Data1;
                end
                sc_of = sc_res[WIDTH-1] ^ i_Data1[WIDTH-1];
            end
            OpRor: begin
                if (sh_amt != '0) begin
                    sc_res = ror_res;
                    sc_c   = ror_res[WIDTH-1];
                end else begin
                    sc_res = i_Data1;
                end
                sc_of = sc_res[WIDTH-1] ^ i_Data1[WIDTH-1];
            end
            // Only reached with a zero divisor; non-zero divisors go to the iterative path.
            OpDivu: begin
                sc_res = '1;
                sc_hi  = i_Data1;
                sc_c   = 1'b0;
                sc_of  = 1'b1;
            end
            default: sc_zs = 1'b0;
        endcase
        sc_z = sc_zs ? (sc_res == '0) : o_Z;
        sc_s = sc_zs ? sc_res[WIDTH-1] : o_S;
    end

    // One iteration step of each multi-cycle operation.
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n, div_diff;
    logic             div_ge;

    assign mul_sum  = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & opnd_q};
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign div_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd_q};
    assign div_diff = WIDTH'(div_sh - {1'b0, opnd_q});
    assign div_hi_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
    assign div_lo_n = {lo_q[WIDTH-2:0], div_ge};

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            o_Result   <= '0;
            o_ResultHi <= '0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_Z        <= 1'b0;
            o_S        <= 1'b0;
            o_C        <= 1'b0;
            o_OF       <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_Start) begin
                        if (i_ALUOp == OpMulu) begin
                            opnd_q  <= i_Data1;
                            lo_q    <= i_Data2;
                            hi_q    <= '0;
                            cnt_q   <= CntInit;
                            o_Busy  <= 1'b1;
                            state_q <= StMul;
                        end else if (i_ALUOp == OpDivu && i_Data2 != '0) begin
                            opnd_q  <= i_Data2;
                            lo_q    <= i_Data1;
                            hi_q    <= '0;
                            cnt_q   <= CntInit;
                            o_Busy  <= 1'b1;
                            state_q <= StDiv;
                        end else begin
                            o_Result   <= sc_res;
                            o_ResultHi <= sc_hi;
                            o_Z        <= sc_z;
                            o_S        <= sc_s;
                            o_C        <= sc_c;
                            o_OF       <= sc_of;
                            o_Done     <= 1'b1;
                        end
                    end
                end
                StMul: begin
                    hi_q  <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        o_Result   <= mul_lo_n;
                        o_ResultHi <= mul_hi_n;
                        o_C        <= |mul_hi_n;
                        o_OF       <= |mul_hi_n;
                        o_Z        <= ~|{mul_hi_n, mul_lo_n};
                        o_S        <= mul_hi_n[WIDTH-1];
                        o_Busy     <= 1'b0;
                        o_Done     <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                StDiv: begin
                    hi_q  <= div_hi_n;
                    lo_q  <= div_lo_n;
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        o_Result   <= div_lo_n;
                        o_ResultHi <= div_hi_n;
                        o_C        <= 1'b0;
                        o_OF       <= 1'b0;
                        o_Z        <= ~|div_lo_n;
                        o_S        <= div_lo_n[WIDTH-1];
                        o_Busy     <= 1'b0;
                        o_Done     <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: integer-arithmetic reference model compared every cycle, plus literal
// expectations for the hand-worked cases.
module tb_alu_seq;

    localparam int W = 8;
    localparam int M = (1 << W) - 1;
    localparam int H = 1 << (W - 1);

    localparam logic [7:0] KRes = 8'h01, KHi = 8'h02, KZ = 8'h04, KS = 8'h08;
    localparam logic [7:0] KC = 8'h10, KOf = 8'h20, KBusy = 8'h40, KDone = 8'h80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] op = '0;
    logic [7:0] d1 = '0, d2 = '0;
    logic [7:0] res, res_hi;
    logic       busy, done, zf, sf, cf, of;

    alu_seq #(.WIDTH(W)) dut (
        .i_CLK(clk), .i_RST(rst), .i_Start(start), .i_ALUOp(op),
        .i_Data1(d1), .i_Data2(d2), .o_Result(res), .o_ResultHi(res_hi),
        .o_Busy(busy), .o_Done(done), .o_Z(zf), .o_S(sf), .o_C(cf), .o_OF(of)
    );

    always #5 clk = ~clk;

    // Reference model state (expected DUT outputs after the latest edge).
    int m_res = 0, m_hi = 0, m_left = 0, p_res = 0, p_hi = 0;
    bit m_z = 0, m_s = 0, m_c = 0, m_of = 0, m_busy = 0, m_done = 0;
    bit p_z = 0, p_s = 0, p_c = 0, p_of = 0;

    int checks = 0, errors = 0;
    bit chk_on = 0;

    logic [7:0] lit_mask = '0;
    string      lit_name = "";
    int         lit_res = 0, lit_hi = 0;
    bit         lit_z = 0, lit_s = 0, lit_c = 0, lit_of = 0, lit_busy = 0, lit_done = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model every cycle, literal expectations when posted.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                cmp("model result", int'(res), m_res);
                cmp("model result_hi", int'(res_hi), m_hi);
                cmp("model Z", int'(zf), int'(m_z));
                cmp("model S", int'(sf), int'(m_s));
                cmp("model C", int'(cf), int'(m_c));
                cmp("model OF", int'(of), int'(m_of));
                cmp("model busy", int'(busy), int'(m_busy));
                cmp("model done", int'(done), int'(m_done));
            end
            if (lit_mask[0]) cmp({lit_name, " result"}, int'(res), lit_res);
            if (lit_mask[1]) cmp({lit_name, " result_hi"}, int'(res_hi), lit_hi);
            if (lit_mask[2]) cmp({lit_name, " Z"}, int'(zf), int'(lit_z));
            if (lit_mask[3]) cmp({lit_name, " S"}, int'(sf), int'(lit_s));
            if (lit_mask[4]) cmp({lit_name, " C"}, int'(cf), int'(lit_c));
            if (lit_mask[5]) cmp({lit_name, " OF"}, int'(of), int'(lit_of));
            if (lit_mask[6]) cmp({lit_name, " busy"}, int'(busy), int'(lit_busy));
            if (lit_mask[7]) cmp({lit_name, " done"}, int'(done), int'(lit_done));
        end
    end

    task automatic model_clear();
        m_res = 0; m_hi = 0; m_z = 0; m_s = 0; m_c = 0; m_of = 0;
        m_busy = 0; m_done = 0; m_left = 0;
    endtask

    task automatic model_single(input int o, input int a, input int b);
        int r, hi, sa, sb, sr, k;
        bit zs;
        r = 0; hi = 0; zs = 1; k = 0; sr = 0;
        sa = (a >= H) ? a - (1 << W) : a;
        sb = (b >= H) ? b - (1 << W) : b;
        case (o)
            0: begin r = a; zs = 0; end
            1: begin r = b; zs = 0; end
            2, 4: begin
                k = (o == 4) ? int'(m_c) : 0;
                r = (a + b + k) & M; m_c = (a + b + k) > M;
                sr = sa + sb + k; m_of = (sr >= H) || (sr < -H);
            end
            3, 5: begin
                k = (o == 5) ? int'(m_c) : 0;
                r = (a - b - k) & M; m_c = a < (b + k);
                sr = sa - sb - k; m_of = (sr >= H) || (sr < -H);
            end
            6: begin r = a & b; m_c = 0; m_of = 0; end
            7: begin r = a | b; m_c = 0; m_of = 0; end
            8: begin r = a ^ b; m_c = 0; m_of = 0; end
            9: begin r = ~a & M; zs = 0; end
            10, 11, 12: begin
                if (b == 0) r = a;
                else if (b >= W) begin
                    r = (o == 12 && a >= H) ? M : 0;
                    m_c = (o == 12) && (a >= H);
                end else if (o == 10) begin
                    r = (a << b) & M; m_c = ((a >> (W - b)) & 1) != 0;
                end else begin
                    r = (o == 11) ? (a >> b) : ((sa >>> b) & M);
                    m_c = ((a >> (b - 1)) & 1) != 0;
                end
                m_of = (r >= H) != (a >= H);
            end
            13, 14: begin
                k = b % W;
                if (k == 0) r = a;
                else if (o == 13) begin
                    r = ((a << k) | (a >> (W - k))) & M; m_c = (r & 1) != 0;
                end else begin
                    r = ((a >> k) | (a << (W - k))) & M; m_c = r >= H;
                end
                m_of = (r >= H) != (a >= H);
            end
            16: begin r = M; hi = a; m_c = 0; m_of = 1; end
            default: zs = 0;
        endcase
        if (zs) begin m_z = (r == 0); m_s = (r >= H); end
        m_res = r; m_hi = hi;
    endtask

    task automatic model_step();
        int a, b, o, p;
        if (rst) begin model_clear(); return; end
        m_done = 0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_res = p_res; m_hi = p_hi; m_z = p_z; m_s = p_s; m_c = p_c; m_of = p_of;
                m_busy = 0; m_done = 1;
            end
        end else if (start) begin
            a = int'(d1); b = int'(d2); o = int'(op);
            if (o == 15) begin
                p = a * b; p_res = p & M; p_hi = p >> W;
                p_c = p_hi != 0; p_of = p_hi != 0; p_z = (p == 0); p_s = p_hi >= H;
                m_busy = 1; m_left = W;
            end else if (o == 16 && b != 0) begin
                p_res = a / b; p_hi = a % b; p_c = 0; p_of = 0;
                p_z = (p_res == 0); p_s = p_res >= H;
                m_busy = 1; m_left = W;
            end else begin
                model_single(o, a, b);
                m_done = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        lit_mask = '0;
    endtask

    task automatic issue(input int o, input int a, input int b);
        start = 1'b1; op = 5'(o); d1 = 8'(a); d2 = 8'(b);
        tick();
        start = 1'b0;
    endtask

    task automatic expect_lit(input string name, input logic [7:0] mask, input int r,
                              input int h, input bit z, input bit s, input bit c, input bit o,
                              input bit b, input bit d);
        lit_name = name; lit_res = r; lit_hi = h; lit_z = z; lit_s = s; lit_c = c;
        lit_of = o; lit_busy = b; lit_done = d;
        lit_mask = mask;
    endtask

    initial begin
        rst = 1'b1;
        model_clear();
        tick();
        tick();
        chk_on = 1'b1;
        expect_lit("reset", 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        expect_lit("idle after reset", KRes | KDone | KBusy, 0, 0, 0, 0, 0, 0, 0, 0);

        issue(2, 'h7F, 'h01);
        expect_lit("add", 8'hBF, 'h80, 0, 0, 1, 0, 1, 0, 1);
        issue(4, 'hFF, 'h00);
        expect_lit("adc", KRes | KC | KDone, 'hFF, 0, 0, 0, 0, 0, 0, 1);
        issue(3, 'h00, 'h01);
        expect_lit("sub", KRes | KC, 'hFF, 0, 0, 0, 1, 0, 0, 1);
        issue(5, 'h05, 'h02);
        expect_lit("sbb", KRes | KC, 'h02, 0, 0, 0, 0, 0, 0, 1);
        issue(12, 'h90, 3);
        expect_lit("sar3", KRes | KC, 'hF2, 0, 0, 0, 0, 0, 0, 1);
        issue(12, 'h90, 9);
        expect_lit("sar9", KRes | KC, 'hFF, 0, 0, 0, 1, 0, 0, 1);
        issue(10, 'h81, 1);
        expect_lit("shl1", KRes | KC | KOf, 'h02, 0, 0, 0, 1, 1, 0, 1);
        issue(14, 'h01, 9);
        expect_lit("ror9", KRes | KC, 'h80, 0, 0, 0, 1, 0, 0, 1);
        tick();
        expect_lit("done pulse", KDone, 0, 0, 0, 0, 0, 0, 0, 0);

        issue(15, 'hFF, 'hFF);
        expect_lit("mulu busy", KBusy | KDone, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) begin start = 1'b1; op = 5'd2; d1 = 8'h11; d2 = 8'h22; end
            tick();
            start = 1'b0;
            expect_lit("mulu busy", KBusy | KDone, 0, 0, 0, 0, 0, 0, 1, 0);
        end
        tick();
        expect_lit("mulu", 8'hFF, 'h01, 'hFE, 0, 1, 1, 1, 0, 1);

        issue(16, 200, 7);
        repeat (8) tick();
        expect_lit("divu", 8'hFF, 28, 4, 0, 0, 0, 0, 0, 1);
        issue(16, 'h35, 0);
        expect_lit("divu by zero", 8'hFF, 'hFF, 'h35, 0, 1, 0, 1, 0, 1);

        issue(15, 'h12, 'h34);
        repeat (3) tick();
        rst = 1'b1;
        model_clear();
        expect_lit("async reset", 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_lit("quiet after reset", KRes | KHi | KBusy | KDone, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        issue(2, 1, 1);
        expect_lit("add after reset", 8'hFF, 'h02, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            int k;
            rst = 1'b0;
            start = ($urandom_range(0, 9) < 7);
            op = ($urandom_range(0, 99) < 90) ? 5'($urandom_range(0, 16))
                                              : 5'($urandom_range(17, 31));
            d1 = 8'($urandom);
            k = int'($urandom_range(0, 9));
            d2 = (k < 3) ? 8'($urandom_range(0, 15)) : ((k == 3) ? 8'd0 : 8'($urandom));
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                model_clear();
            end
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        tick();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
